// File: rtl/output_stream_controller_if.sv
// AXI-Stream bundle between the output stream controller (master) and the DMA port (slave).
interface output_stream_controller_if #(
  parameter int unsigned BEAT_WIDTH = 8
);
  logic [BEAT_WIDTH-1:0] maxis_tdata;
  logic                  maxis_tvalid;
  logic                  maxis_tlast;
  logic                  maxis_tready;

  modport master (
    output maxis_tdata,
    output maxis_tvalid,
    output maxis_tlast,
    input  maxis_tready
  );

  modport slave (
    input  maxis_tdata,
    input  maxis_tvalid,
    input  maxis_tlast,
    output maxis_tready
  );
endinterface

// File: rtl/output_stream_controller.sv
// Streams a decoded frame from the output-buffer BRAM, packing words LSB first into
// AXI-Stream beats through a 2-entry FIFO, and pulses output_done once the last beat is taken.
module output_stream_controller #(
  parameter int unsigned            CODE_LENGTH     = 1024,
  parameter int unsigned            ADDR_WIDTH      = 10,
  parameter int unsigned            BRAM_DATA_WIDTH = 1,
  parameter int unsigned            BEAT_WIDTH      = 8,
  parameter int unsigned            STATE_WIDTH     = 10,
  parameter logic [STATE_WIDTH-1:0] OUTPUT_STATE    = 10'd512
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [STATE_WIDTH-1:0]     state,
  input  logic [ADDR_WIDTH:0]        frame_length,
  input  logic [BRAM_DATA_WIDTH-1:0] data_from_output_buffer_bram,
  output logic [ADDR_WIDTH-1:0]      addr_to_output_buffer_bram,
  output logic                       read_enable_to_output_buffer_bram,
  output_stream_controller_if.master maxis,
  output logic                       output_done,
  output logic [ADDR_WIDTH:0]        beat_count
);

  localparam int unsigned         PACK       = BEAT_WIDTH / BRAM_DATA_WIDTH;
  localparam int unsigned         WIB_W      = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [ADDR_WIDTH:0] CODE_LEN_L = (ADDR_WIDTH+1)'(CODE_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } phase_t;

  phase_t                         phase;
  logic [ADDR_WIDTH:0]            len_q;
  logic [ADDR_WIDTH:0]            rd_idx;
  logic [WIB_W-1:0]               word_in_beat;
  logic [BEAT_WIDTH-1:0]          beat_q;
  logic                           rd_valid_q;
  logic                           rd_last_q;
  logic [1:0][BEAT_WIDTH-1:0]     fifo_data;
  logic [1:0]                     fifo_last;
  logic [1:0]                     fifo_count;

  logic                           in_state;
  logic                           entry;
  logic [ADDR_WIDTH:0]            len_in;
  logic [ADDR_WIDTH:0]            eff_len;
  logic                           pop;
  logic                           word_close;
  logic                           push;
  logic [2:0]                     occ;
  logic                           read_en;
  logic [BEAT_WIDTH-1:0]          beat_w;

  always_comb begin
    in_state   = (state == OUTPUT_STATE);
    entry      = in_state && (phase == ST_IDLE);
    len_in     = (frame_length > CODE_LEN_L) ? CODE_LEN_L : frame_length;
    // frame_length is used directly on the entry cycle so the first read issues immediately
    eff_len    = entry ? len_in : len_q;
    pop        = (fifo_count != 2'd0) && maxis.maxis_tready;
    word_close = (32'(word_in_beat) == PACK - 1) || rd_last_q;
    push       = rd_valid_q && word_close;
    occ        = {1'b0, fifo_count} + {2'b00, push};
    // A same-cycle pop frees a slot, keeping PACK=1 streams gap-free without overflow
    read_en    = reset_n && in_state && (phase != ST_DONE) && (rd_idx < eff_len)
                 && (fifo_count != 2'd2) && (occ < (pop ? 3'd3 : 3'd2));
  end

  always_comb begin
    beat_w = beat_q;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (32'(word_in_beat) == k) begin
        beat_w[k*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH] = data_from_output_buffer_bram;
      end
    end
  end

  assign addr_to_output_buffer_bram        = rd_idx[ADDR_WIDTH-1:0];
  assign read_enable_to_output_buffer_bram = read_en;
  assign maxis.maxis_tdata                 = fifo_data[0];
  assign maxis.maxis_tvalid                = (fifo_count != 2'd0);
  assign maxis.maxis_tlast                 = fifo_last[0] && (fifo_count != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= ST_IDLE;
      len_q        <= '0;
      rd_idx       <= '0;
      word_in_beat <= '0;
      beat_q       <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      fifo_data    <= '0;
      fifo_last    <= '0;
      fifo_count   <= '0;
      output_done  <= 1'b0;
      beat_count   <= '0;
    end else begin
      output_done <= 1'b0;
      if (!in_state) begin
        // Leaving the output state flushes everything, including a read still in flight
        phase        <= ST_IDLE;
        rd_idx       <= '0;
        word_in_beat <= '0;
        beat_q       <= '0;
        rd_valid_q   <= 1'b0;
        rd_last_q    <= 1'b0;
        fifo_data    <= '0;
        fifo_last    <= '0;
        fifo_count   <= '0;
      end else begin
        rd_valid_q <= read_en;
        if (read_en) begin
          rd_idx    <= rd_idx + 1'b1;
          rd_last_q <= (rd_idx == eff_len - 1'b1);
        end

        if (rd_valid_q) begin
          if (word_close) begin
            word_in_beat <= '0;
            beat_q       <= '0;
          end else begin
            word_in_beat <= word_in_beat + 1'b1;
            beat_q       <= beat_w;
          end
        end

        unique case ({push, pop})
          2'b10: begin
            if (fifo_count == 2'd0) begin
              fifo_data[0] <= beat_w;
              fifo_last[0] <= rd_last_q;
            end else begin
              fifo_data[1] <= beat_w;
              fifo_last[1] <= rd_last_q;
            end
            fifo_count <= fifo_count + 2'd1;
          end
          2'b01: begin
            fifo_data[0] <= fifo_data[1];
            fifo_last[0] <= fifo_last[1];
            fifo_count   <= fifo_count - 2'd1;
          end
          2'b11: begin
            if (fifo_count == 2'd1) begin
              fifo_data[0] <= beat_w;
              fifo_last[0] <= rd_last_q;
            end else begin
              fifo_data[0] <= fifo_data[1];
              fifo_last[0] <= fifo_last[1];
              fifo_data[1] <= beat_w;
              fifo_last[1] <= rd_last_q;
            end
          end
          default: ;
        endcase

        if (entry) begin
          len_q       <= len_in;
          beat_count  <= '0;
          phase       <= (len_in == '0) ? ST_DONE : ST_STREAM;
          output_done <= (len_in == '0);
        end else begin
          if (pop) beat_count <= beat_count + 1'b1;
          if (pop && fifo_last[0]) begin
            output_done <= 1'b1;
            phase       <= ST_DONE;
          end
        end
      end
    end
  end

endmodule

// File: doc/output_stream_controller.md
# output_stream_controller

Parametrised successor to the single-bit output streamer. While the main FSM is in the output state, it reads a decoded codeword from the output-buffer BRAM. It packs BRAM words into wider AXI-Stream beats, LSB first, and sends them with full backpressure tolerance through a 2-entry output FIFO. It signals frame completion back to the main FSM. It sits between the output-buffer BRAM and the DMA/M_AXIS port.

## Interface
Parameters:
- CODE_LENGTH, 1024, maximum frame length in BRAM words
- ADDR_WIDTH, 10, BRAM address width; 2^ADDR_WIDTH >= CODE_LENGTH
- BRAM_DATA_WIDTH, 1, BRAM read-data width
- BEAT_WIDTH, 8, maxis_tdata width; integer multiple of BRAM_DATA_WIDTH; PACK = BEAT_WIDTH/BRAM_DATA_WIDTH
- STATE_WIDTH, 10, main-FSM state width
- OUTPUT_STATE, 10'd512, state encoding in which streaming is active

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- state  in  STATE_WIDTH  main-FSM state
- frame_length  in  ADDR_WIDTH+1  words to send; legal range 0..CODE_LENGTH; sampled on the first cycle state==OUTPUT_STATE
- data_from_output_buffer_bram  in  BRAM_DATA_WIDTH  BRAM read data, 1-cycle latency
- addr_to_output_buffer_bram  out  ADDR_WIDTH  BRAM read address
- read_enable_to_output_buffer_bram  out  1  BRAM read strobe
- maxis_tdata  out  BEAT_WIDTH  packed beat
- maxis_tvalid  out  1  beat valid
- maxis_tlast  out  1  final beat of frame
- maxis_tready  in  1  downstream ready
- output_done  out  1  one-cycle pulse when the frame is fully accepted
- beat_count  out  ADDR_WIDTH+1  beats accepted in the current frame

## Operation
- Reset (reset_n low) clears the following to 0: all counters, the packer, the FIFO, and every output.
- Entry is a cycle where state==OUTPUT_STATE and it was not in the prior cycle. On entry:
  - len is latched from frame_length.
  - rd_idx, word_in_beat, beat_count and the FIFO are cleared.
  - total_beats = ceil(len/PACK).
- **Read issue:** read_enable is high when all of the following hold:
  - state==OUTPUT_STATE
  - not done
  - rd_idx < len
  - fifo_count + pending < 2, where pending=1 if the read issued in the previous cycle completes a beat
- addr_to_output_buffer_bram = rd_idx; rd_idx increments on each issued read.
- **Packing:** BRAM data that returns one cycle after a read is placed at bit offset word_in_beat*BRAM_DATA_WIDTH.
  - A beat closes when word_in_beat==PACK-1 or the word is index len-1.
  - On close, the beat is pushed to the FIFO and word_in_beat resets to 0.
  - Bits of a partial final beat that are never filled are 0.
- **FIFO:** 2 entries, each holding tdata plus a last flag. The last flag is set on the beat containing word len-1.
  - The head drives maxis_tdata/maxis_tlast.
  - maxis_tvalid = (fifo_count != 0).
  - Push and pop in the same cycle leave the count unchanged.
  - The issue gating above guarantees the FIFO never overflows.
- **Handshake:** a pop occurs when maxis_tvalid && maxis_tready; beat_count increments on each pop.
  - tdata and tlast hold stable while tvalid is high and tready is low.
- **Completion:** a pop with tlast set asserts output_done for exactly one cycle, starting the next cycle, and sets done.
  - done blocks further reads until the next entry.
- **len==0:** no reads and no beats; output_done pulses in the cycle after entry.
- **Abort:** if state leaves OUTPUT_STATE mid-frame, the following happen in the next cycle:
  - the FIFO and packer flush;
  - tvalid drops;
  - no output_done pulse is generated;
  - a read in flight is discarded.
- Re-entry always restarts from word 0.

## Timing
- Read issue is combinational from registered counters, fifo_count, state and maxis_tready.
- Throughput is one BRAM word per cycle when unstalled; sustained output is one beat per PACK cycles.
- First-beat latency, with entry in cycle 0 and maxis_tready high:
  - reads are issued in cycles 0..PACK-1;
  - the beat is pushed at the end of cycle PACK;
  - maxis_tvalid is high in cycle PACK+1.
- With PACK=1, len words stream back-to-back: tvalid is continuous from cycle 2 to cycle len+1.
- When maxis_tready is low, reads stop no later than the point at which the FIFO holds 2 beats; no data is lost or duplicated.
- output_done is registered: it occurs one cycle after the tlast handshake.
- beat_count updates in the cycle after each pop.

## Test plan
- **PACK=1 smoke test.** Stimulus: BRAM_DATA_WIDTH=1, BEAT_WIDTH=1, len=1024, tready=1, BRAM preloaded with addr[0]. Required response:
  - 1024 beats alternating 0,1;
  - tlast only on beat 1023;
  - output_done at cycle 1026;
  - beat_count=1024.
- **Packing.** Stimulus: BEAT_WIDTH=8, BRAM_DATA_WIDTH=1, len=20, bits = addr%3==0. Required response:
  - 3 beats: 8'h49, 8'h92, 8'h04;
  - tlast on the third beat;
  - upper 4 bits of the third beat are 0.
- **Backpressure.** Stimulus: tready toggles randomly, 30% high, len=64, PACK=8. Required response:
  - exactly 8 beats in order;
  - tdata stable while stalled;
  - read_enable is never issued when fifo_count==2.
- **Abort.** Stimulus: state leaves OUTPUT_STATE after 3 beats of a 16-beat frame, then re-enters with len=8. Required response:
  - tvalid drops the next cycle;
  - no output_done pulse for the aborted frame;
  - the new frame restarts at addr 0 with 1 beat and done.
- **Async reset.** Stimulus: reset_n pulsed low mid-frame, asynchronously. Required response:
  - all outputs read 0 immediately;
  - a clean restart on the next entry.
- **Zero length.** Stimulus: len=0. Required response:
  - no read_enable and no tvalid;
  - output_done pulses in the cycle after entry.
